// File: rtl/seg_pkg.sv
// seg_pkg: shared constants, segment code table and FSM states for the 7-segment serial link.
package seg_pkg;
    localparam int FRAME_BITS_DEF = 33;
    localparam int FILLER_BIT = 32;
    localparam int HI_BASE = 16;
    localparam int LO_BASE = 0;
    // ABCDEFG codes with segment A in bit 0, indexed by hex value 0-F
    localparam logic [15:0][6:0] SEG_CODES = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };
    typedef enum logic [1:0] {IDLE, SHIFT, DECODE} state_t;
    // Gather digit k's segments as {g,f,e,d,c,b,a}; g,f,a,b ride in the high half, e,d,c in the low half
    function automatic logic [6:0] unpack_seg(input logic [FRAME_BITS_DEF-1:0] w, input int k);
        logic [3:0] hi, lo;
        hi = w[HI_BASE + 4*k +: 4];
        lo = w[LO_BASE + 4*(3-k) +: 4];
        return {hi[3], hi[2], lo[2], lo[1], lo[0], hi[0], hi[1]};
    endfunction
endpackage

// File: rtl/seg_to_hex.sv
// seg_to_hex: maps a 7-bit ABCDEFG pattern to {valid, hex}; unknown patterns give 0.
module seg_to_hex
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [4:0] code
);
    always_comb begin
        code = '0;
        for (int i = 0; i < 16; i++)
            if (seg == SEG_CODES[i]) code = {1'b1, 4'(i)};
    end
endmodule

// File: rtl/seg_frame_rx.sv
// seg_frame_rx: deserialises a 33-bit 7-segment frame and recovers digits, temperature or out-of-range.
module seg_frame_rx
    import seg_pkg::*;
#(
    parameter int FRAME_BITS   = FRAME_BITS_DEF,
    parameter int IDLE_TIMEOUT = 4096,
    parameter int SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        seg_clk,
    input  logic        seg_ser,
    output logic [15:0] digits,
    output logic [3:0]  dp,
    output logic [3:0]  digit_valid,
    output logic [9:0]  temp,
    output logic        temp_valid,
    output logic        oor,
    output logic        frame_valid,
    output logic        frame_err
);
    localparam int TW = $clog2(IDLE_TIMEOUT);
    localparam int CW = $clog2(FRAME_BITS + 1);

    logic [SYNC_STAGES-1:0] clk_sync, ser_sync;
    logic clk_q, rise, bit_q;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [FRAME_BITS-1:0] word;
    logic load, err_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync <= '0;
            ser_sync <= '0;
            clk_q    <= 1'b0;
            rise     <= 1'b0;
            bit_q    <= 1'b0;
            state    <= IDLE;
            cnt      <= '0;
            tcnt     <= '0;
            word     <= '0;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], seg_clk};
            ser_sync <= {ser_sync[SYNC_STAGES-2:0], seg_ser};
            clk_q    <= clk_sync[SYNC_STAGES-1];
            rise     <= clk_sync[SYNC_STAGES-1] & ~clk_q;
            bit_q    <= ~ser_sync[SYNC_STAGES-1];
            state    <= state_n;
            cnt      <= cnt_n;
            tcnt     <= tcnt_n;
            if (rise) word <= {bit_q, word[FRAME_BITS-1:1]};
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        tcnt_n  = '0;
        load    = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                state_n = rise ? SHIFT : IDLE;
                cnt_n   = rise ? CW'(1) : '0;
            end
            SHIFT: begin
                tcnt_n = rise ? '0 : tcnt + 1'b1;
                cnt_n  = cnt + CW'(rise);
                if (cnt_n == CW'(FRAME_BITS)) state_n = DECODE;
                else if (!rise && tcnt == TW'(IDLE_TIMEOUT - 1)) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            DECODE: begin
                load    = ~word[FILLER_BIT];
                err_n   = word[FILLER_BIT];
                state_n = rise ? SHIFT : IDLE;
                cnt_n   = rise ? CW'(1) : '0;
            end
            default: state_n = IDLE;
        endcase
    end

    logic [19:0] codes;
    logic [15:0] dig_c;
    logic [3:0]  dv_c, dp_c;
    logic [10:0] sum;
    logic        tv_c, oor_c;

    for (genvar k = 0; k < 4; k++) begin : g_dec
        seg_to_hex u_dec (.seg(unpack_seg(word, k)), .code(codes[5*k +: 5]));
        assign dig_c[4*k +: 4] = codes[5*k +: 4];
        assign dv_c[k]         = codes[5*k + 4];
        assign dp_c[k]         = word[4*k + 3];
    end

    // d3*100 + d2*10 + d1 built from shifts only
    assign sum = (11'(dig_c[15:12]) << 6) + (11'(dig_c[15:12]) << 5) + (11'(dig_c[15:12]) << 2)
               + (11'(dig_c[11:8]) << 3) + (11'(dig_c[11:8]) << 1) + 11'(dig_c[7:4]);
    assign tv_c = dv_c == 4'hF && dig_c[3:0] == 4'hC && dp_c == 4'b0100 && dig_c[15:12] <= 4'hA
               && dig_c[11:8] <= 4'd9 && dig_c[7:4] <= 4'd9 && sum <= 11'd1023;
    assign oor_c = dig_c == 16'hDEAD && dv_c == 4'hF && dp_c == 4'b0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits      <= '0;
            dp          <= '0;
            digit_valid <= '0;
            temp        <= '0;
            temp_valid  <= 1'b0;
            oor         <= 1'b0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= load;
            frame_err   <= err_n;
            if (load) begin
                digits      <= dig_c;
                dp          <= dp_c;
                digit_valid <= dv_c;
                temp        <= tv_c ? sum[9:0] : '0;
                temp_valid  <= tv_c;
                oor         <= oor_c;
            end
        end
    end
endmodule

// File: tb/tb_seg_frame_rx.sv
// tb_seg_frame_rx: drives frames over the serial link and checks every decode pulse against a digit-level model.
module tb_seg_frame_rx;
    logic clk = 1'b0, rst_n = 1'b0, seg_clk = 1'b0, seg_ser = 1'b1;
    logic [15:0] digits;
    logic [3:0] dp, digit_valid;
    logic [9:0] temp;
    logic temp_valid, oor, frame_valid, frame_err;

    always #5 clk = ~clk;

    seg_frame_rx dut (
        .clk(clk), .rst_n(rst_n), .seg_clk(seg_clk), .seg_ser(seg_ser),
        .digits(digits), .dp(dp), .digit_valid(digit_valid), .temp(temp),
        .temp_valid(temp_valid), .oor(oor), .frame_valid(frame_valid), .frame_err(frame_err)
    );

    localparam logic [15:0][6:0] TBL = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef struct packed {
        logic        err;
        logic [15:0] digits;
        logic [3:0]  dp;
        logic [3:0]  dv;
        logic [9:0]  temp;
        logic        tv;
        logic        oor;
    } exp_t;

    int n_cmp = 0, n_bad = 0;
    exp_t cur = '0;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".digits"}, 32'(digits), 32'(cur.digits));
        chk({tag, ".dp"}, 32'(dp), 32'(cur.dp));
        chk({tag, ".digit_valid"}, 32'(digit_valid), 32'(cur.dv));
        chk({tag, ".temp"}, 32'(temp), 32'(cur.temp));
        chk({tag, ".temp_valid"}, 32'(temp_valid), 32'(cur.tv));
        chk({tag, ".oor"}, 32'(oor), 32'(cur.oor));
    endtask

    function automatic logic [3:0][6:0] segs_of(input logic [15:0] hex);
        logic [3:0][6:0] s;
        for (int k = 0; k < 4; k++) s[k] = TBL[hex[4*k +: 4]];
        return s;
    endfunction

    // Frame layout: digit k's g,f,a,b at 16+4k+3..16+4k; dp[j] then e,d,c of digit 3-j at 4j+3..4j
    function automatic logic [32:0] pack(input logic [3:0][6:0] s, input logic [3:0] dpv, input bit bad);
        logic [32:0] w;
        w[32] = bad;
        for (int k = 0; k < 4; k++) begin
            w[16 + 4*k + 3] = s[k][6];
            w[16 + 4*k + 2] = s[k][5];
            w[16 + 4*k + 1] = s[k][0];
            w[16 + 4*k]     = s[k][1];
        end
        for (int j = 0; j < 4; j++) begin
            w[4*j + 3] = dpv[j];
            w[4*j + 2] = s[3-j][4];
            w[4*j + 1] = s[3-j][3];
            w[4*j]     = s[3-j][2];
        end
        return w;
    endfunction

    function automatic exp_t model(input logic [3:0][6:0] s, input logic [3:0] dpv, input bit bad);
        exp_t e;
        int d[4];
        int total;
        e = '0;
        e.err = bad;
        e.dp = dpv;
        for (int k = 0; k < 4; k++) begin
            d[k] = 0;
            for (int i = 0; i < 16; i++)
                if (s[k] == TBL[i]) begin
                    d[k] = i;
                    e.dv[k] = 1'b1;
                end
            e.digits[4*k +: 4] = 4'(d[k]);
        end
        total = d[3] * 100 + d[2] * 10 + d[1];
        e.tv = e.dv == 4'hF && d[0] == 12 && dpv == 4'b0100 && d[3] <= 10 && d[2] <= 9 && d[1] <= 9
               && total <= 1023;
        e.temp = e.tv ? 10'(total) : 10'd0;
        e.oor = e.digits == 16'hDEAD && e.dv == 4'hF && dpv == 4'b0000;
        return e;
    endfunction

    task automatic send_bit(input logic b, input int half);
        seg_ser = ~b;
        #(half * 10);
        seg_clk = 1'b1;
        #(half * 10);
        seg_clk = 1'b0;
    endtask

    task automatic send_frame(input logic [3:0][6:0] s, input logic [3:0] dpv, input bit bad, input int half);
        logic [32:0] w;
        w = pack(s, dpv, bad);
        exp_q.push_back(model(s, dpv, bad));
        for (int i = 0; i < 33; i++) send_bit(w[i], half);
        seg_ser = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int limit);
        for (int i = 0; i < limit && exp_q.size() != 0; i++) @(negedge clk);
        chk({name, ".pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && (frame_valid || frame_err)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {30'd0, frame_valid, frame_err}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pulse.err", 32'(frame_err), 32'(e.err));
                chk("pulse.valid", 32'(frame_valid), 32'(!e.err));
                if (!e.err) cur = e;
                check_outputs("pulse");
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, pending=%0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0][6:0] s;
        logic [32:0] w;
        repeat (4) @(negedge clk);
        check_outputs("reset");
        chk("reset.pulses", {30'd0, frame_valid, frame_err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #3;

        send_frame(segs_of(16'h725C), 4'b0100, 1'b0, 512);
        wait_drain("t1", 50);
        chk("t1.temp", 32'(temp), 32'd725);
        chk("t1.temp_valid", 32'(temp_valid), 32'd1);
        chk("t1.oor", 32'(oor), 32'd0);
        chk("t1.digit_valid", 32'(digit_valid), 32'hF);

        send_frame(segs_of(16'hDEAD), 4'b0000, 1'b0, 8);
        wait_drain("t2", 50);
        chk("t2.oor", 32'(oor), 32'd1);
        chk("t2.temp_valid", 32'(temp_valid), 32'd0);
        chk("t2.digits", 32'(digits), 32'hDEAD);

        exp_q.push_back('{err: 1'b1, default: '0});
        w = pack(segs_of(16'h123C), 4'b0100, 1'b0);
        for (int i = 0; i < 20; i++) send_bit(w[i], 8);
        seg_ser = 1'b1;
        wait_drain("t3", 4300);
        check_outputs("t3.hold");
        chk("t3.digits", 32'(digits), 32'hDEAD);

        send_frame(segs_of(16'hA23C), 4'b0100, 1'b0, 6);
        wait_drain("t4a", 50);
        chk("t4a.temp", 32'(temp), 32'd1023);
        chk("t4a.temp_valid", 32'(temp_valid), 32'd1);
        send_frame(segs_of(16'hA29C), 4'b0100, 1'b0, 6);
        wait_drain("t4b", 50);
        chk("t4b.temp", 32'(temp), 32'd0);
        chk("t4b.temp_valid", 32'(temp_valid), 32'd0);

        s = segs_of(16'h725C);
        s[1] = 7'h00;
        send_frame(s, 4'b0100, 1'b0, 5);
        wait_drain("t5", 50);
        chk("t5.digit_valid", 32'(digit_valid), 32'b1101);
        chk("t5.temp_valid", 32'(temp_valid), 32'd0);

        w = pack(segs_of(16'h725C), 4'b0100, 1'b0);
        for (int i = 0; i < 15; i++) send_bit(w[i], 7);
        rst_n = 1'b0;
        cur = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t6.rst_pulse", {30'd0, frame_valid, frame_err}, 32'd0);
        end
        check_outputs("t6.reset");
        rst_n = 1'b1;
        @(negedge clk);
        #3;
        send_frame(segs_of(16'h725C), 4'b0100, 1'b0, 7);
        wait_drain("t6", 50);
        chk("t6.temp", 32'(temp), 32'd725);

        send_frame(segs_of(16'h725C), 4'b0100, 1'b0, 4);
        #(80);
        send_frame(segs_of(16'h725C), 4'b0100, 1'b0, 4);
        wait_drain("t7", 50);

        for (int n = 0; n < 14; n++) begin
            logic [3:0] dpv;
            bit bad;
            int half;
            if ($urandom_range(0, 1) == 1) begin
                s = segs_of({4'($urandom_range(0, 10)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'hC});
                dpv = 4'b0100;
            end else begin
                for (int k = 0; k < 4; k++)
                    s[k] = ($urandom_range(0, 7) == 0) ? 7'($urandom) : TBL[$urandom_range(0, 15)];
                dpv = 4'($urandom);
            end
            bad = $urandom_range(0, 7) == 0;
            half = $urandom_range(3, 12);
            send_frame(s, dpv, bad, half);
            #($urandom_range(0, 2) * half * 20);
        end
        wait_drain("rand", 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
